// File: rtl/fetch_unit.sv
// Instruction-fetch front end: program counter, prefetch FIFO and memory fetch FSM.
// Optional FETCH_PERF_EN adds a saturating stall_count output.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0200,
  parameter int          QDEPTH   = 2,
  parameter logic [7:0]  NOP_OP   = 8'hEA
) (
  input  logic        clk_2,
  input  logic        rst,
  input  logic        increment,
  input  logic        lower_byte,
  input  logic        pc_data,
  input  logic        branch_uncon,
  input  logic        branch_con,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  instruction,
  output logic        flush,
  output logic        normal,
  output logic [15:0] pc
`ifdef FETCH_PERF_EN
  ,output logic [15:0] stall_count
`endif
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t         state, state_n;
  logic [7:0]     fifo_mem [QDEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  count, count_n;
  logic [15:0]    fetch_addr, fetch_addr_n;
  logic [15:0]    req_addr, req_addr_n;
  logic [15:0]    pc_n;
  logic           drop, drop_n;
  logic           redirect, ack_ok, push, pop;
  logic           space_n, new_req;

  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Occupancy used for the fetch decision is the post-edge value, so an
  // accepted byte is already counted and the FIFO can never overflow.
  always_comb begin
    redirect = branch_uncon | (branch_con & branch_taken);
    ack_ok   = (state == REQ) & mem_ack;
    push     = ack_ok & ~drop & ~redirect;
    pop      = increment & normal & ~redirect;

    count_n = count;
    if (redirect)          count_n = '0;
    else if (push & ~pop)  count_n = count + CW'(1);
    else if (pop & ~push)  count_n = count - CW'(1);
    space_n = (count_n < CW'(QDEPTH));

    fetch_addr_n = fetch_addr;
    if (redirect)  fetch_addr_n = branch_target;
    else if (push) fetch_addr_n = fetch_addr + 16'd1;

    // A redirect while a request is still pending marks its data as stale.
    drop_n = drop;
    if (ack_ok) drop_n = 1'b0;
    if (redirect && (state == REQ) && !mem_ack) drop_n = 1'b1;

    state_n = state;
    case (state)
      IDLE:    if (pc_data && space_n) state_n = REQ;
      REQ:     if (mem_ack) state_n = (pc_data && space_n) ? REQ : IDLE;
      default: state_n = IDLE;
    endcase

    new_req    = (state_n == REQ) && !((state == REQ) && !mem_ack);
    req_addr_n = new_req ? fetch_addr_n : req_addr;

    pc_n = pc;
    if (redirect)
      pc_n = branch_target;
    else if (pop)
      pc_n = lower_byte ? {pc[15:8], 8'(pc[7:0] + 8'd1)} : pc + 16'd1;
  end

  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
      req_addr   <= RESET_PC;
      drop       <= 1'b0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      flush      <= 1'b0;
    end else begin
      pc         <= pc_n;
      fetch_addr <= fetch_addr_n;
      req_addr   <= req_addr_n;
      drop       <= drop_n;
      count      <= count_n;
      flush      <= redirect;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk_2) begin
    if (push) fifo_mem[wr_ptr] <= mem_rdata;
  end

  always_comb begin
    mem_req     = (state == REQ);
    mem_addr    = (state == REQ) ? req_addr : fetch_addr;
    normal      = (count != '0);
    instruction = normal ? fifo_mem[rd_ptr] : NOP_OP;
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst)
      stall_count <= 16'h0000;
    else if (!normal && !flush && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: randomized decoder/memory traffic against
// a byte-stream reference model (fetch sequence, pc rule, buffered-byte count).
module tb_fetch_unit;

  localparam int QDEPTH = 2;

  logic        clk_2, rst;
  logic        increment, lower_byte, pc_data;
  logic        branch_uncon, branch_con, branch_taken;
  logic [15:0] branch_target;
  logic        mem_req, mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata, instruction;
  logic        flush, normal;
  logic [15:0] pc;
`ifdef FETCH_PERF_EN
  logic [15:0] stall_count;
`endif

  fetch_unit #(.RESET_PC(16'h0200), .QDEPTH(QDEPTH), .NOP_OP(8'hEA)) dut (
    .clk_2(clk_2), .rst(rst), .increment(increment), .lower_byte(lower_byte),
    .pc_data(pc_data), .branch_uncon(branch_uncon), .branch_con(branch_con),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .instruction(instruction), .flush(flush),
    .normal(normal), .pc(pc)
`ifdef FETCH_PERF_EN
    ,.stall_count(stall_count)
`endif
  );

  typedef struct packed {logic [15:0] pc; logic [7:0] b;} pop_rec_t;

  pop_rec_t    pop_q[$];
  int          flush_cyc_q[$];
  logic [15:0] flush_tgt_q[$];

  int          total = 0, passed = 0;
  int          cyc = 0, epoch = 0, buffered = 0, ack_total = 0, stall_exp = 0;
  logic        prev_redir = 1'b0, ack_live;
  logic [15:0] exp_pc = 16'h0200, exp_fetch = 16'h0200;
  logic        pc_data_v = 1'b1;
  int          min_wait = 0, max_wait = 0;

  initial begin
    clk_2 = 1'b0;
    forever #5 clk_2 = ~clk_2;
  end

  function automatic logic [7:0] memf(input logic [15:0] a);
    case (a)
      16'h0200: memf = 8'h69;
      16'h0201: memf = 8'h05;
      16'h0202: memf = 8'hEA;
      default:  memf = 8'(a[7:0] * 8'd13) ^ a[15:8] ^ 8'h3C;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk_2) cyc <= cyc + 1;

  // Reference: bytes held = accepted live acks minus pops, emptied on redirect/reset.
  always @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      buffered   <= 0;
      epoch      <= epoch + 1;
      prev_redir <= 1'b0;
    end else begin
      prev_redir <= branch_uncon | (branch_con & branch_taken);
      if (branch_uncon | (branch_con & branch_taken)) begin
        buffered <= 0;
        epoch    <= epoch + 1;
      end else begin
        buffered <= buffered + (ack_live ? 1 : 0) - ((increment && buffered > 0) ? 1 : 0);
      end
    end
  end

  initial begin : responder
    int lat, late, req_epoch;
    logic [15:0] raddr;
    lat = -1; late = 0; req_epoch = 0; raddr = 16'h0;
    mem_ack = 1'b0; mem_rdata = 8'h00; ack_live = 1'b0;
    forever begin
      @(posedge clk_2); #2;
      mem_ack = 1'b0; ack_live = 1'b0;
      if (rst) begin
        if (lat >= 0) late = 1;
        lat = -1;
      end else if (late != 0) begin
        late = 0; mem_ack = 1'b1; mem_rdata = 8'hFF;
      end else if (lat < 0) begin
        if (mem_req) begin
          lat = $urandom_range(max_wait, min_wait);
          raddr = mem_addr; req_epoch = epoch;
        end
      end else begin
        check_output("req held until ack", 32'(mem_req), 32'd1);
        check_output("mem_addr stable", 32'(mem_addr), 32'(raddr));
        if (lat == 0) begin
          mem_ack = 1'b1; mem_rdata = memf(raddr);
          ack_live = (req_epoch == epoch);
          ack_total++; lat = -1;
        end else lat--;
      end
    end
  end

  always @(negedge clk_2) begin
    if (rst) begin
      stall_exp = 0;
    end else begin
      check_output("normal vs model", 32'(normal), 32'(buffered != 0));
      check_output("occupancy bound", 32'(buffered <= QDEPTH), 32'd1);
      if (!normal) check_output("nop when empty", 32'(instruction), 32'h00EA);
      if (increment && normal && !(branch_uncon | (branch_con & branch_taken))) begin
        if (pop_q.size() == 0) check_output("unexpected pop", 32'd1, 32'd0);
        else begin
          pop_rec_t r;
          r = pop_q.pop_front();
          check_output("instruction", 32'(instruction), 32'(r.b));
          check_output("pc at pop", 32'(pc), 32'(r.pc));
        end
      end
      if (flush_cyc_q.size() > 0 && flush_cyc_q[0] + 1 == cyc) begin
        check_output("flush pulse", 32'(flush), 32'd1);
        check_output("pc after redirect", 32'(pc), 32'(flush_tgt_q[0]));
        void'(flush_cyc_q.pop_front());
        void'(flush_tgt_q.pop_front());
      end else begin
        check_output("no spurious flush", 32'(flush), 32'd0);
      end
      if (buffered == 0 && !prev_redir) stall_exp++;
    end
  end

  task automatic apply_stimulus(input logic inc, input logic lb, input logic bu,
                                input logic bc, input logic bt, input logic [15:0] tgt);
    increment = inc; lower_byte = lb; branch_uncon = bu; branch_con = bc;
    branch_taken = bt; branch_target = tgt; pc_data = pc_data_v;
    if (bu | (bc & bt)) begin
      flush_cyc_q.push_back(cyc);
      flush_tgt_q.push_back(tgt);
      exp_pc = tgt; exp_fetch = tgt;
    end else if (inc && normal === 1'b1) begin
      pop_q.push_back({exp_pc, memf(exp_fetch)});
      exp_pc = lb ? {exp_pc[15:8], 8'(exp_pc[7:0] + 8'd1)} : exp_pc + 16'd1;
      exp_fetch = exp_fetch + 16'd1;
    end
  endtask

  task automatic tick();
    @(posedge clk_2); #1;
  endtask

  task automatic step(input logic inc, input logic lb, input logic bu,
                      input logic bc, input logic bt, input logic [15:0] tgt);
    tick();
    apply_stimulus(inc, lb, bu, bc, bt, tgt);
  endtask

  task automatic wait_normal(input int limit);
    int n = 0;
    do begin step(0, 0, 0, 0, 0, 16'h0); n++; end while (normal !== 1'b1 && n < limit);
    if (normal !== 1'b1) check_output("wait normal timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_req(input int limit, input logic popping);
    int n = 0;
    do begin step(popping, 0, 0, 0, 0, 16'h0); n++; end while (mem_req !== 1'b1 && n < limit);
    if (mem_req !== 1'b1) check_output("wait req timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_state();
    check_output("reset pc", 32'(pc), 32'h0200);
    check_output("reset mem_req", 32'(mem_req), 32'd0);
    check_output("reset normal", 32'(normal), 32'd0);
    check_output("reset flush", 32'(flush), 32'd0);
    check_output("reset instruction", 32'(instruction), 32'h00EA);
  endtask

  task automatic random_run(input int cycles);
    logic bu, bc, bt, inc, lb;
    logic [15:0] tgt;
    int r;
    for (int i = 0; i < cycles; i++) begin
      if (i % 100 == 0) begin min_wait = 0; max_wait = $urandom_range(0, 3); end
      pc_data_v = ($urandom_range(0, 7) != 0);
      r   = $urandom_range(0, 99);
      bu  = (r < 3);
      bc  = (r >= 3 && r < 8);
      bt  = 1'($urandom_range(0, 1));
      tgt = (r == 0) ? 16'hFFFE : 16'($urandom);
      inc = ($urandom_range(0, 9) < 7);
      lb  = ($urandom_range(0, 7) == 0);
      step(inc, lb, bu, bc, bt, tgt);
    end
  endtask

  initial begin
    int a0, n, saw_low, rerise;
    rst = 1'b1;
    increment = 0; lower_byte = 0; pc_data = 1; branch_uncon = 0;
    branch_con = 0; branch_taken = 0; branch_target = 16'h0;
    repeat (3) tick();
    check_reset_state();
    rst = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 16'h0);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 16'h0);
    check_output("first req", 32'(mem_req), 32'd1);
    check_output("first addr", 32'(mem_addr), 32'h0200);
    check_output("not normal before ack", 32'(normal), 32'd0);

    repeat (8) step(0, 0, 0, 0, 0, 16'h0);
    check_output("no req when full", 32'(mem_req), 32'd0);
    a0 = ack_total;
    step(1, 0, 0, 0, 0, 16'h0);
    n = 0;
    repeat (8) begin
      step(0, 0, 0, 0, 0, 16'h0);
      if (mem_req && n == 0) begin
        check_output("refill addr", 32'(mem_addr), 32'h0202);
        n = 1;
      end
    end
    check_output("exactly one refill", 32'(ack_total - a0), 32'd1);

    min_wait = 4; max_wait = 4;
    step(1, 0, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 0, 16'h0);
    step(0, 0, 0, 0, 0, 16'h0);
    check_output("pc after three pops", 32'(pc), 32'h0203);
    check_output("req 0203 outstanding", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0203});
    step(0, 0, 1, 0, 0, 16'h1234);
    n = 0;
    do begin step(0, 0, 0, 0, 0, 16'h0); n++; end
      while (!(mem_req && mem_addr != 16'h0203) && n < 20);
    check_output("addr after redirect", 32'(mem_addr), 32'h1234);
    min_wait = 0; max_wait = 2;

    step(0, 0, 0, 1, 0, 16'hBEEF);
    repeat (2) step(0, 0, 0, 0, 0, 16'h0);
    check_output("pc after con not taken", 32'(pc), 32'h1234);

    step(0, 0, 1, 0, 0, 16'h12FF);
    wait_normal(30);
    step(1, 1, 0, 0, 0, 16'h0);
    wait_normal(30);
    check_output("lower_byte wrap", 32'(pc), 32'h1200);
    step(1, 0, 0, 0, 0, 16'h0);

    min_wait = 1; max_wait = 1;
    wait_req(30, 1);
    pc_data_v = 1'b0;
    a0 = ack_total; saw_low = 0; rerise = 0;
    repeat (12) begin
      step(1, 0, 0, 0, 0, 16'h0);
      if (!mem_req) saw_low = 1;
      else if (saw_low != 0) rerise = 1;
    end
    check_output("inflight completes", 32'(ack_total > a0), 32'd1);
    check_output("req drops with pc_data low", 32'(saw_low), 32'd1);
    check_output("no req while pc_data low", 32'(rerise), 32'd0);
    pc_data_v = 1'b1;
    wait_req(6, 1);
    check_output("req resumes", 32'(mem_req), 32'd1);

    random_run(1500);

    wait_req(30, 1);
    tick();
    rst = 1'b1;
    apply_stimulus(0, 0, 0, 0, 0, 16'h0);
    pop_q.delete(); flush_cyc_q.delete(); flush_tgt_q.delete();
    exp_pc = 16'h0200; exp_fetch = 16'h0200;
    tick();
    check_reset_state();
    tick();
    rst = 1'b0;
    pc_data_v = 1'b1; min_wait = 0; max_wait = 1;
    apply_stimulus(0, 0, 0, 0, 0, 16'h0);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 16'h0);
    check_output("req after mid reset", 32'(mem_req), 32'd1);
    check_output("addr after mid reset", 32'(mem_addr), 32'h0200);

    random_run(300);
    step(0, 0, 0, 0, 0, 16'h0);
`ifdef FETCH_PERF_EN
    check_output("stall_count", 32'(stall_count), 32'(stall_exp));
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
